// File: rtl/axi_wsched_pkg.sv
// axi_wsched_pkg: shared constants and state type for the W-channel scheduler
package axi_wsched_pkg;
   localparam int CNT_W    = 9;
   localparam int BEAT_SAT = 256;
   typedef enum logic {IDLE, ROUTE} state_t;
endpackage

// File: rtl/axi_wdata_scheduler_if.sv
// axi_wdata_scheduler_if: order-entry and W-channel bundle for the scheduler
// Signals: push_i/src_sel_i/grant_o/push_err_o (order entries from the AW arbiter),
//   s_w* (per-initiator W, packed with initiator 0 at the LSBs), m_w* (target W),
//   burst_done_o/beat_cnt_o (burst status). slave = scheduler view, master = driver view.
interface axi_wdata_scheduler_if #(
   parameter int N_TARG_PORT = 4,
   parameter int DATA_WIDTH  = 64
);
   import axi_wsched_pkg::*;
   logic                                  push_i;
   logic [N_TARG_PORT-1:0]                src_sel_i;
   logic                                  grant_o;
   logic                                  push_err_o;
   logic [N_TARG_PORT-1:0]                s_wvalid_i;
   logic [N_TARG_PORT-1:0]                s_wlast_i;
   logic [N_TARG_PORT*DATA_WIDTH-1:0]     s_wdata_i;
   logic [N_TARG_PORT*DATA_WIDTH/8-1:0]   s_wstrb_i;
   logic [N_TARG_PORT-1:0]                s_wready_o;
   logic                                  m_wvalid_o;
   logic [DATA_WIDTH-1:0]                 m_wdata_o;
   logic [DATA_WIDTH/8-1:0]               m_wstrb_o;
   logic                                  m_wlast_o;
   logic                                  m_wready_i;
   logic                                  burst_done_o;
   logic [CNT_W-1:0]                      beat_cnt_o;
   modport slave (
      input  push_i, src_sel_i, s_wvalid_i, s_wlast_i, s_wdata_i, s_wstrb_i, m_wready_i,
      output grant_o, push_err_o, s_wready_o, m_wvalid_o, m_wdata_o, m_wstrb_o, m_wlast_o,
             burst_done_o, beat_cnt_o
   );
   modport master (
      output push_i, src_sel_i, s_wvalid_i, s_wlast_i, s_wdata_i, s_wstrb_i, m_wready_i,
      input  grant_o, push_err_o, s_wready_o, m_wvalid_o, m_wdata_o, m_wstrb_o, m_wlast_o,
             burst_done_o, beat_cnt_o
   );
endinterface

// File: rtl/axi_wsched_order_fifo.sv
// axi_wsched_order_fifo: FIFO of one-hot initiator selects, head read from storage (no fall-through)
// Ports: clk, rst (sync, active-high); i_push/i_din write, i_pop read (both ignored when
//   full/empty), o_dout head entry, o_full, o_cnt occupancy (one bit wider than the pointers).
module axi_wsched_order_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_din,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp, r_rp;
   logic [CW-1:0]    r_cnt;
   logic             w_wr, w_rd;
   assign o_full = (r_cnt == CW'(DEPTH));
   assign w_wr   = i_push & ~o_full;
   assign w_rd   = i_pop & (r_cnt != '0);
   assign o_dout = r_mem[r_rp];
   assign o_cnt  = r_cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= r_wp + AW'(w_wr);
         r_rp  <= r_rp + AW'(w_rd);
         r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp] <= i_din;
   end
endmodule

// File: rtl/axi_wdata_scheduler.sv
// axi_wdata_scheduler: routes initiator W bursts to one target port in AW grant order
// Build option: AXI_WSCHED_REG_SLICE_EN adds a registered 2-entry skid buffer on the target path.
// Ports: clk, rst (sync, active-high); bus (slave modport): push_i/src_sel_i order entries with
//   grant_o and push_err_o, s_w* per-initiator W inputs and s_wready_o, m_w* target W channel,
//   burst_done_o pulse per WLAST handshake, beat_cnt_o beats in the current burst.
module axi_wdata_scheduler import axi_wsched_pkg::*; #(
   parameter int N_TARG_PORT = 4,
   parameter int DATA_WIDTH  = 64,
   parameter int FIFO_DEPTH  = 8
) (
   input logic                  clk,
   input logic                  rst,
   axi_wdata_scheduler_if.slave bus
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t                 r_state;
   logic                   r_done, r_err;
   logic [CNT_W-1:0]       r_beat, w_beat_base;
   logic [N_TARG_PORT-1:0] w_head, w_sel;
   logic [CW-1:0]          w_cnt, w_occ_nxt;
   logic                   w_full, w_push_ok, w_vin, w_lin, w_in_rdy, w_hs, w_pop;
   logic [DATA_WIDTH-1:0]  w_din;
   logic [SW-1:0]          w_sin;
   assign w_push_ok = bus.push_i & $onehot(bus.src_sel_i);
   axi_wsched_order_fifo #(.WIDTH(N_TARG_PORT), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .i_push(w_push_ok), .i_pop(w_pop), .i_din(bus.src_sel_i),
      .o_dout(w_head), .o_full(w_full), .o_cnt(w_cnt)
   );
   assign bus.grant_o = ~w_full;
   assign w_sel = (r_state == ROUTE) ? w_head : '0;
   always_comb begin
      w_din = '0;
      w_sin = '0;
      for (int i = 0; i < N_TARG_PORT; i++) begin
         w_din = w_din | (w_sel[i] ? bus.s_wdata_i[i*DATA_WIDTH +: DATA_WIDTH] : '0);
         w_sin = w_sin | (w_sel[i] ? bus.s_wstrb_i[i*SW +: SW] : '0);
      end
   end
   assign w_vin = |(bus.s_wvalid_i & w_sel);
   assign w_lin = |(bus.s_wlast_i & w_sel);
   assign w_hs  = w_vin & w_in_rdy;
   assign w_pop = w_hs & w_lin;
   assign bus.s_wready_o = w_sel & {N_TARG_PORT{w_in_rdy}};
   // full blocks the push even when the head pops in the same cycle
   assign w_occ_nxt   = w_cnt + CW'(w_push_ok & ~w_full) - CW'(w_pop);
   // the count shows the final beat for one cycle (alongside burst_done) before clearing
   assign w_beat_base = r_done ? '0 : r_beat;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_beat  <= '0;
      end else begin
         r_state <= (w_occ_nxt != '0) ? ROUTE : IDLE;
         r_done  <= w_pop;
         r_err   <= bus.push_i & ~$onehot(bus.src_sel_i);
         r_beat  <= (w_hs && w_beat_base != CNT_W'(BEAT_SAT)) ? w_beat_base + CNT_W'(1) : w_beat_base;
      end
   end
   assign bus.burst_done_o = r_done;
   assign bus.push_err_o   = r_err;
   assign bus.beat_cnt_o   = r_beat;
`ifdef AXI_WSCHED_REG_SLICE_EN
   logic                  r_v, r_sv, r_l, r_sl;
   logic [DATA_WIDTH-1:0] r_d, r_sd;
   logic [SW-1:0]         r_s, r_ss;
   // ready depends only on the skid slot, so it is registered and still full-throughput
   assign w_in_rdy = ~r_sv;
   always_ff @(posedge clk) begin
      if (rst) begin
         {r_v, r_sv, r_l, r_sl} <= '0;
         {r_d, r_sd, r_s, r_ss} <= '0;
      end else if (~r_v | bus.m_wready_i) begin
         r_v               <= r_sv | w_hs;
         {r_d, r_s, r_l}   <= r_sv ? {r_sd, r_ss, r_sl} : {w_din, w_sin, w_lin};
         r_sv              <= 1'b0;
      end else if (w_hs) begin
         r_sv              <= 1'b1;
         {r_sd, r_ss, r_sl} <= {w_din, w_sin, w_lin};
      end
   end
   assign bus.m_wvalid_o = r_v;
   assign bus.m_wdata_o  = r_d;
   assign bus.m_wstrb_o  = r_s;
   assign bus.m_wlast_o  = r_l;
`else
   assign w_in_rdy       = bus.m_wready_i;
   assign bus.m_wvalid_o = w_vin;
   assign bus.m_wdata_o  = w_din;
   assign bus.m_wstrb_o  = w_sin;
   assign bus.m_wlast_o  = w_lin;
`endif
endmodule

// File: tb/tb_axi_wdata_scheduler.sv
// tb_axi_wdata_scheduler: scoreboard and vector-table bench for axi_wdata_scheduler
module tb_axi_wdata_scheduler;
   localparam int N = 4, DW = 64, SW = 8, DEPTH = 8;
`ifdef AXI_WSCHED_REG_SLICE_EN
   localparam bit SLICE = 1'b1;
`else
   localparam bit SLICE = 1'b0;
`endif
   typedef struct packed {logic [DW-1:0] d; logic [SW-1:0] s; logic l;} beat_t;
   typedef struct {logic push; logic [N-1:0] sel; logic err; logic grant;} vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   axi_wdata_scheduler_if #(.N_TARG_PORT(N), .DATA_WIDTH(DW)) bus ();
   axi_wdata_scheduler #(.N_TARG_PORT(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   always #5 clk = ~clk;
   beat_t        src_mem [N][512];
   int           src_wr [N];
   int           src_rd [N];
   beat_t        exp_q[$];
   logic [N-1:0] aw_q[$];
   logic [N-1:0] stray, adv;
   bit           tog;
   int           total, bad, done_cnt, max_beat, cyc, first_hs, last_hs, first_v;
   logic [8:0]   exp_beat;
   logic         exp_done, exp_err;
   vec_t         vt [13];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int idx(input logic [N-1:0] s);
      for (int i = 0; i < N; i++) if (s[i]) return i;
      return 0;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         beat_t b;
         b = src_mem[i][src_rd[i]];
         bus.s_wvalid_i[i]          = (src_rd[i] < src_wr[i]) | stray[i];
         bus.s_wlast_i[i]           = b.l;
         bus.s_wdata_i[i*DW +: DW]  = b.d;
         bus.s_wstrb_i[i*SW +: SW]  = b.s;
      end
   endtask

   task automatic send_burst(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         beat_t b;
         b.d = {$urandom, $urandom};
         b.s = 8'($urandom);
         b.l = (k == n - 1);
         src_mem[i][src_wr[i]] = b;
         src_wr[i]++;
         exp_q.push_back(b);
      end
      drive();
   endtask

   task automatic step();
      logic [N-1:0] head;
      logic         src_hs, src_last, done_n, err_n;
      logic [8:0]   base, beat_n;
      int           pre;
      #1;
      adv  = bus.s_wvalid_i & bus.s_wready_o;
      head = (aw_q.size() > 0) ? aw_q[0] : '0;
      chk("wready_unselected", 128'(bus.s_wready_o & ~head), 128'(0));
      if (bus.m_wvalid_o) begin
         if (first_v < 0) first_v = cyc;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got data %0h with no beat expected", bus.m_wdata_o);
         end else begin
            chk("m_beat", 128'({bus.m_wdata_o, bus.m_wstrb_o, bus.m_wlast_o}), 128'(exp_q[0]));
            if (bus.m_wready_i) begin
               void'(exp_q.pop_front());
               if (first_hs < 0) first_hs = cyc;
               last_hs = cyc;
            end
         end
      end
      if (bus.burst_done_o) done_cnt++;
      if (int'(bus.beat_cnt_o) > max_beat) max_beat = int'(bus.beat_cnt_o);
      src_hs   = |adv;
      src_last = |(adv & bus.s_wlast_i);
      pre      = aw_q.size();
      if (rst) aw_q.delete();
      else begin
         if (src_last && pre > 0) void'(aw_q.pop_front());
         if (bus.push_i && $onehot(bus.src_sel_i) && pre < DEPTH) aw_q.push_back(bus.src_sel_i);
      end
      base   = exp_done ? 9'd0 : exp_beat;
      beat_n = rst ? 9'd0 : (src_hs && base != 9'd256) ? base + 9'd1 : base;
      done_n = !rst && src_last;
      err_n  = !rst && bus.push_i && !$onehot(bus.src_sel_i);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (adv[i]) src_rd[i]++;
      if (tog) bus.m_wready_i = ~bus.m_wready_i;
      drive();
      exp_beat = beat_n;
      exp_done = done_n;
      exp_err  = err_n;
      cyc++;
      @(negedge clk);
      chk("beat_cnt", 128'(bus.beat_cnt_o), 128'(exp_beat));
      chk("burst_done", 128'(bus.burst_done_o), 128'(exp_done));
      chk("push_err", 128'(bus.push_err_o), 128'(exp_err));
   endtask

   task automatic aw(input logic [N-1:0] sel);
      bus.src_sel_i = sel;
      bus.push_i    = 1'b1;
      step();
      bus.push_i    = 1'b0;
   endtask

   task automatic drain(input int lim);
      int n = 0;
      while (exp_q.size() != 0 && n < lim) begin
         step();
         n++;
      end
      chk("drain_timeout", 128'(exp_q.size()), 128'(0));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_grant"}, 128'(bus.grant_o), 128'(1));
      chk({tag, "_m_wvalid"}, 128'(bus.m_wvalid_o), 128'(0));
      chk({tag, "_m_wlast"}, 128'(bus.m_wlast_o), 128'(0));
      chk({tag, "_m_wdata"}, 128'(bus.m_wdata_o), 128'(0));
      chk({tag, "_m_wstrb"}, 128'(bus.m_wstrb_o), 128'(0));
      chk({tag, "_s_wready"}, 128'(bus.s_wready_o), 128'(0));
   endtask

   initial begin
      int c, n;
      vt[0]  = '{1'b1, 4'b0110, 1'b1, 1'b1};
      vt[1]  = '{1'b1, 4'b0000, 1'b1, 1'b1};
      vt[2]  = '{1'b1, 4'b0001, 1'b0, 1'b1};
      vt[3]  = '{1'b1, 4'b0010, 1'b0, 1'b1};
      vt[4]  = '{1'b1, 4'b0100, 1'b0, 1'b1};
      vt[5]  = '{1'b1, 4'b1000, 1'b0, 1'b1};
      vt[6]  = '{1'b1, 4'b0001, 1'b0, 1'b1};
      vt[7]  = '{1'b1, 4'b0010, 1'b0, 1'b1};
      vt[8]  = '{1'b1, 4'b0100, 1'b0, 1'b1};
      vt[9]  = '{1'b1, 4'b1000, 1'b0, 1'b0};
      vt[10] = '{1'b1, 4'b0001, 1'b0, 1'b0};
      vt[11] = '{1'b1, 4'b1111, 1'b1, 1'b0};
      vt[12] = '{1'b0, 4'b0000, 1'b0, 1'b0};
      for (int i = 0; i < N; i++) begin
         src_wr[i] = 0;
         src_rd[i] = 0;
      end
      {total, bad, done_cnt, max_beat, cyc} = '0;
      first_hs = -1;
      last_hs  = -1;
      first_v  = -1;
      exp_beat = '0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      stray    = '0;
      tog      = 1'b0;
      bus.push_i     = 1'b0;
      bus.src_sel_i  = '0;
      bus.m_wready_i = 1'b1;
      drive();
      step();
      step();
      chk_reset_outputs("reset");
      rst = 1'b0;
      step();
      // single 4-beat burst from initiator 1, routed the cycle after the push
      send_burst(1, 4);
      done_cnt = 0;
      aw(4'b0010);
      chk("t1_first_valid", 128'(bus.m_wvalid_o), 128'(!SLICE));
      drain(20);
      step();
      chk("t1_done_count", 128'(done_cnt), 128'(1));
      chk("t1_idle", 128'(bus.m_wvalid_o), 128'(0));
      // back-to-back bursts, no bubble between them
      send_burst(0, 3);
      send_burst(3, 2);
      first_hs = -1;
      aw(4'b0001);
      aw(4'b1000);
      drain(20);
      chk("t2_span", 128'(last_hs - first_hs), 128'(4));
      step();
      // vector table: error pushes, fill to full, push while full
      for (int i = 0; i < 13; i++) begin
         bus.src_sel_i = vt[i].sel;
         bus.push_i    = vt[i].push;
         step();
         bus.push_i    = 1'b0;
         chk($sformatf("tbl%0d_err", i), 128'(bus.push_err_o), 128'(vt[i].err));
         chk($sformatf("tbl%0d_grant", i), 128'(bus.grant_o), 128'(vt[i].grant));
      end
      // push and pop in the same cycle while full: push is dropped
      send_burst(0, 1);
      aw(4'b0010);
      chk("full_pushpop_grant", 128'(bus.grant_o), 128'(1));
      chk("full_pushpop_occ", 128'(aw_q.size()), 128'(7));
      for (int k = 0; k < aw_q.size(); k++) send_burst(idx(aw_q[k]), 2);
      drain(100);
      step();
      chk("drained_grant", 128'(bus.grant_o), 128'(1));
      chk("drained_idle", 128'(bus.m_wvalid_o), 128'(0));
      // valid from an initiator with no order entry is never forwarded
      stray = 4'b0010;
      drive();
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stray_valid", 128'(bus.m_wvalid_o), 128'(0));
         chk("stray_ready", 128'(bus.s_wready_o), 128'(0));
      end
      stray = '0;
      drive();
      // 8-beat burst with toggling target ready
      send_burst(1, 8);
      max_beat = 0;
      first_v  = -1;
      c = cyc;
      tog = 1'b1;
      aw(4'b0010);
      drain(60);
      tog = 1'b0;
      bus.m_wready_i = 1'b1;
      step();
      chk("t6_latency", 128'(first_v - c), 128'(1 + int'(SLICE)));
      chk("t6_beat_max", 128'(max_beat), 128'(8));
      // beat counter saturation
      send_burst(2, 260);
      max_beat = 0;
      aw(4'b0100);
      drain(400);
      step();
      chk("sat_beat_max", 128'(max_beat), 128'(256));
      chk("sat_cleared", 128'(bus.beat_cnt_o), 128'(0));
      // reset after beat 2 of a 4-beat burst
      send_burst(2, 4);
      aw(4'b0100);
      n = 0;
      while (src_rd[2] < src_wr[2] - 2 && n < 10) begin
         step();
         n++;
      end
      chk("t5_two_beats", 128'(src_wr[2] - src_rd[2]), 128'(2));
      rst = 1'b1;
      step();
      chk_reset_outputs("t5");
      chk("t5_beat", 128'(bus.beat_cnt_o), 128'(0));
      rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < N; i++) src_rd[i] = src_wr[i];
      stray = 4'b0100;
      drive();
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t5_fifo_empty", 128'(bus.m_wvalid_o), 128'(0));
      end
      stray = '0;
      drive();
      // recovery burst after reset
      send_burst(3, 3);
      done_cnt = 0;
      aw(4'b1000);
      drain(20);
      step();
      chk("recover_done", 128'(done_cnt), 128'(1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
